// File: rtl/sifive_reset_source.sv
// Board reset source: sequences PLL/MMCM reset, waits for stable lock, and produces areset for the downstream sequencer.
// Optional reset-cause capture is enabled by defining SIFIVE_RESET_CAUSE_EN.
module sifive_reset_source #(
  parameter int unsigned NUM_LOCKS       = 2,
  parameter int unsigned PLL_RST_CYCLES  = 8,
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 256,
  parameter int unsigned SW_HOLD_CYCLES  = 16
) (
  input  logic                 clock,
  input  logic                 areset_n,
  input  logic [NUM_LOCKS-1:0] locked,
  input  logic                 button,
  input  logic                 sw_reset_req,
`ifdef SIFIVE_RESET_CAUSE_EN
  input  logic                 cause_clear,
  output logic [3:0]           reset_cause,
`endif
  output logic                 pll_reset,
  output logic                 areset,
  output logic                 running
);

  localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > SW_HOLD_CYCLES) ? PLL_RST_CYCLES : SW_HOLD_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_SW_HOLD   = 3'd4
  } state_t;

  logic [NUM_LOCKS-1:0] lock_s1, lock_s2;
  logic                 btn_s1, btn_s2;
  logic                 all_locked;
  logic [DB_W-1:0]      db_cnt;
  logic                 btn_db, btn_db_q;
  logic                 btn_event;
  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 pll_reset_d, areset_d, running_d;

  // Two-flop synchronizers for the asynchronous lock and button inputs
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
    end else begin
      lock_s1 <= locked;
      lock_s2 <= lock_s1;
      btn_s1  <= button;
      btn_s2  <= btn_s1;
    end
  end

  assign all_locked = &lock_s2;

  // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign btn_event = btn_db & ~btn_db_q;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      areset    <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pll_reset <= pll_reset_d;
      areset    <= areset_d;
      running   <= running_d;
    end
  end

  // Next-state logic; the counter is cleared on every state change so it never wraps
  always_comb begin
    state_d = state;
    cnt_d   = cnt + CNT_W'(1);
    case (state)
      S_PLL_RST: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (all_locked) state_d = S_STABLE;
      end
      S_STABLE: begin
        if (!all_locked) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!all_locked || btn_event) state_d = S_PLL_RST;
        else if (sw_reset_req)        state_d = S_SW_HOLD;
      end
      S_SW_HOLD: begin
        if (cnt == CNT_W'(SW_HOLD_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
    pll_reset_d = (state_d == S_PLL_RST);
    areset_d    = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
  end

`ifdef SIFIVE_RESET_CAUSE_EN
  logic [3:0] cause_set;

  // Cause bits latch on the edge leaving RUN; lock loss and button may both be recorded
  always_comb begin
    cause_set = '0;
    if ((state == S_RUN) && (state_d != S_RUN)) begin
      cause_set[1] = ~all_locked;
      cause_set[2] = btn_event;
      cause_set[3] = all_locked & ~btn_event;
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) reset_cause <= 4'b0001;
    else           reset_cause <= (cause_clear ? 4'b0000 : reset_cause) | cause_set;
  end
`endif

endmodule

// File: tb/tb_sifive_reset_source.sv
// Directed self-checking bench for sifive_reset_source (small parameters for short runs).
module tb_sifive_reset_source;

  logic       clock = 1'b0;
  logic       areset_n;
  logic [1:0] locked;
  logic       button;
  logic       sw_reset_req;
  logic       pll_reset, areset, running;
`ifdef SIFIVE_RESET_CAUSE_EN
  logic       cause_clear;
  logic [3:0] reset_cause;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int pll_rises = 0;
  logic pll_q = 1'b1;

  sifive_reset_source #(
    .NUM_LOCKS(2), .PLL_RST_CYCLES(8), .STABLE_CYCLES(16),
    .DEBOUNCE_CYCLES(32), .SW_HOLD_CYCLES(16)
  ) dut (
    .clock(clock),
    .areset_n(areset_n),
    .locked(locked),
    .button(button),
    .sw_reset_req(sw_reset_req),
`ifdef SIFIVE_RESET_CAUSE_EN
    .cause_clear(cause_clear),
    .reset_cause(reset_cause),
`endif
    .pll_reset(pll_reset),
    .areset(areset),
    .running(running)
  );

  always #5 clock = ~clock;

  // Counts PLL reset pulses, sampled away from the active edge
  always @(negedge clock) begin
    if (pll_reset && !pll_q) pll_rises = pll_rises + 1;
    pll_q = pll_reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    areset_n = 1'b0; locked = 2'b11; button = 1'b0; sw_reset_req = 1'b0;
`ifdef SIFIVE_RESET_CAUSE_EN
    cause_clear = 1'b0;
`endif
    step(2);
    n_checks++; if (pll_reset !== 1'b1) begin n_fails++; $display("FAIL rst_pll: got %b want 1", pll_reset); end
    n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL rst_areset: got %b want 1", areset); end
    n_checks++; if (running !== 1'b0) begin n_fails++; $display("FAIL rst_running: got %b want 0", running); end
`ifdef SIFIVE_RESET_CAUSE_EN
    n_checks++; if (reset_cause !== 4'b0001) begin n_fails++; $display("FAIL rst_cause: got %b want 0001", reset_cause); end
`endif
  endtask

  // Release at E0; PLL_RST exits at E8, STABLE from E9, RUN at E25
  task automatic test_power_up;
    areset_n = 1'b1;
    step(7);
    n_checks++; if (pll_reset !== 1'b1) begin n_fails++; $display("FAIL pwr_pll_e7: got %b want 1", pll_reset); end
    step(1);
    n_checks++; if (pll_reset !== 1'b0) begin n_fails++; $display("FAIL pwr_pll_e8: got %b want 0", pll_reset); end
    step(16);
    n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL pwr_areset_e24: got %b want 1", areset); end
    n_checks++; if (running !== 1'b0) begin n_fails++; $display("FAIL pwr_running_e24: got %b want 0", running); end
    step(1);
    n_checks++; if (areset !== 1'b0) begin n_fails++; $display("FAIL pwr_areset_e25: got %b want 0", areset); end
    n_checks++; if (running !== 1'b1) begin n_fails++; $display("FAIL pwr_running_e25: got %b want 1", running); end
  endtask

  // STABLE entered at S=E9; lock glitch at count 10; locks high again from S+12 so RUN at S+12+2+16
  task automatic test_stable_glitch;
    areset_n = 1'b0;
    step(1);
    areset_n = 1'b1;
    step(19);
    locked = 2'b01;
    step(1);
    locked = 2'b11;
    for (int i = 0; i < 18; i++) begin
      step(1);
      n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL glitch_hold cyc %0d: areset=%b want 1", 12 + i, areset); end
    end
    step(1);
    n_checks++; if (areset !== 1'b0) begin n_fails++; $display("FAIL glitch_release: areset=%b want 0", areset); end
    n_checks++; if (running !== 1'b1) begin n_fails++; $display("FAIL glitch_running: got %b want 1", running); end
  endtask

  // Lock loss in RUN at R: PLL_RST R+3..R+11, RUN again at R+28
  task automatic test_lock_loss;
    locked = 2'b10;
    step(2);
    n_checks++; if (areset !== 1'b0) begin n_fails++; $display("FAIL loss_r2_areset: got %b want 0", areset); end
`ifdef SIFIVE_RESET_CAUSE_EN
    cause_clear = 1'b1;
`endif
    step(1);
`ifdef SIFIVE_RESET_CAUSE_EN
    cause_clear = 1'b0;
    n_checks++; if (reset_cause !== 4'b0010) begin n_fails++; $display("FAIL loss_cause: got %b want 0010", reset_cause); end
`endif
    locked = 2'b11;
    n_checks++; if (pll_reset !== 1'b1) begin n_fails++; $display("FAIL loss_pll_r3: got %b want 1", pll_reset); end
    n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL loss_areset_r3: got %b want 1", areset); end
    step(7);
    n_checks++; if (pll_reset !== 1'b1) begin n_fails++; $display("FAIL loss_pll_r10: got %b want 1", pll_reset); end
    step(1);
    n_checks++; if (pll_reset !== 1'b0) begin n_fails++; $display("FAIL loss_pll_r11: got %b want 0", pll_reset); end
    step(16);
    n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL loss_areset_r27: got %b want 1", areset); end
    step(1);
    n_checks++; if (areset !== 1'b0) begin n_fails++; $display("FAIL loss_areset_r28: got %b want 0", areset); end
  endtask

  task automatic test_button;
    int base;
    base = pll_rises;
    for (int i = 0; i < 3; i++) begin
      button = 1'b1; step(10);
      button = 1'b0; step(10);
    end
    n_checks++; if (pll_rises - base !== 0) begin n_fails++; $display("FAIL btn_bounce: pll pulses=%0d want 0", pll_rises - base); end
    n_checks++; if (running !== 1'b1) begin n_fails++; $display("FAIL btn_bounce_run: got %b want 1", running); end
    // Held press at P: debounced level flips at P+34, PLL_RST entered at P+35
    button = 1'b1;
    step(34);
    n_checks++; if (pll_reset !== 1'b0) begin n_fails++; $display("FAIL btn_p34: pll_reset=%b want 0", pll_reset); end
    step(1);
    n_checks++; if (pll_reset !== 1'b1) begin n_fails++; $display("FAIL btn_p35: pll_reset=%b want 1", pll_reset); end
    step(5);
    button = 1'b0;
    step(80);
    n_checks++; if (pll_rises - base !== 1) begin n_fails++; $display("FAIL btn_once: pll pulses=%0d want 1", pll_rises - base); end
    n_checks++; if (running !== 1'b1) begin n_fails++; $display("FAIL btn_rerun: got %b want 1", running); end
`ifdef SIFIVE_RESET_CAUSE_EN
    n_checks++; if (reset_cause !== 4'b0110) begin n_fails++; $display("FAIL btn_cause: got %b want 0110", reset_cause); end
`endif
  endtask

  // Request at X: SW_HOLD X+1..X+17, STABLE from X+18, RUN at X+34; a second request in STABLE is ignored
  task automatic test_sw_reset;
    int base;
    base = pll_rises;
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL sw_areset_x1: got %b want 1", areset); end
    n_checks++; if (pll_reset !== 1'b0) begin n_fails++; $display("FAIL sw_pll_x1: got %b want 0", pll_reset); end
    step(19);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    step(12);
    n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL sw_areset_x33: got %b want 1", areset); end
    step(1);
    n_checks++; if (areset !== 1'b0) begin n_fails++; $display("FAIL sw_areset_x34: got %b want 0", areset); end
    n_checks++; if (pll_rises - base !== 0) begin n_fails++; $display("FAIL sw_no_pll: pll pulses=%0d want 0", pll_rises - base); end
`ifdef SIFIVE_RESET_CAUSE_EN
    n_checks++; if (reset_cause !== 4'b1110) begin n_fails++; $display("FAIL sw_cause: got %b want 1110", reset_cause); end
`endif
  endtask

  task automatic test_async_reset;
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    step(21);
    n_checks++; if (pll_reset !== 1'b0) begin n_fails++; $display("FAIL ares_pre_pll: got %b want 0", pll_reset); end
    #3;
    areset_n = 1'b0;
    #1;
    n_checks++; if (pll_reset !== 1'b1) begin n_fails++; $display("FAIL ares_pll: got %b want 1", pll_reset); end
    n_checks++; if (areset !== 1'b1) begin n_fails++; $display("FAIL ares_areset: got %b want 1", areset); end
    n_checks++; if (running !== 1'b0) begin n_fails++; $display("FAIL ares_running: got %b want 0", running); end
`ifdef SIFIVE_RESET_CAUSE_EN
    n_checks++; if (reset_cause !== 4'b0001) begin n_fails++; $display("FAIL ares_cause: got %b want 0001", reset_cause); end
`endif
    step(1);
    areset_n = 1'b1;
    step(4);
    n_checks++; if (pll_reset !== 1'b1) begin n_fails++; $display("FAIL ares_restart_pll: got %b want 1", pll_reset); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_stable_glitch();
    test_lock_loss();
    test_button();
    test_sw_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
